// File: rtl/single_backprop_layer2.sv
`default_nettype none
// ============================================================================
//  Module   : single_backprop_layer2 (+ single_add, single_mult, fp_delay)
//  Purpose  : Output-layer backward pass: delta = y - t, dW2 = l*delta,
//             dl = W2*delta, computed serially on one FP adder and one FP
//             multiplier (IEEE-754 single, RNE, denormals flushed to zero).
//  Revision : 1.0  initial release
// ============================================================================

// Result delay line: STAGES register stages between arithmetic and consumer.
module fp_delay #(
    parameter int STAGES = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);
    generate
        if (STAGES <= 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [31:0] r_stage [STAGES];
            // shift result through the pipeline stages
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
                end else begin
                    r_stage[0] <= i_d;
                    for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
                end
            end
            assign o_q = r_stage[STAGES-1];
        end
    endgenerate
endmodule

// Single-precision adder. The consumer's register is the last stage, so only
// LAT-1 internal stages are inserted.
module single_add #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    logic [31:0] w_big, w_sml, w_res;
    logic [7:0]  w_eb, w_es, w_d;
    logic [26:0] w_mb, w_ms, w_sh, w_n;
    logic [27:0] w_s;
    logic [4:0]  w_lz;
    logic [9:0]  w_ex, w_ex2, w_ef;
    logic [24:0] w_r;
    logic        w_st, w_found;

    // align smaller operand, add/subtract, normalise, round to nearest even
    always_comb begin
        w_big   = (i_a[30:0] >= i_b[30:0]) ? i_a : i_b;
        w_sml   = (i_a[30:0] >= i_b[30:0]) ? i_b : i_a;
        w_eb    = w_big[30:23];
        w_es    = w_sml[30:23];
        w_mb    = (w_eb == 8'd0) ? 27'd0 : {1'b1, w_big[22:0], 3'b000};
        w_ms    = (w_es == 8'd0) ? 27'd0 : {1'b1, w_sml[22:0], 3'b000};
        w_d     = w_eb - w_es;
        if (w_d >= 8'd27) begin
            w_sh = 27'd0;
            w_st = |w_ms;
        end else begin
            w_sh = w_ms >> w_d;
            w_st = |(w_ms & ~(27'h7FF_FFFF << w_d));
        end
        w_sh    = {w_sh[26:1], w_sh[0] | w_st};
        w_s     = (w_big[31] == w_sml[31]) ? ({1'b0, w_mb} + {1'b0, w_sh})
                                           : ({1'b0, w_mb} - {1'b0, w_sh});
        w_lz    = 5'd0;
        w_found = 1'b0;
        for (int k = 26; k >= 0; k--) begin
            if (!w_found) begin
                if (w_s[k]) w_found = 1'b1;
                else        w_lz    = w_lz + 5'd1;
            end
        end
        if (w_s[27]) begin
            w_n  = {w_s[27:2], w_s[1] | w_s[0]};
            w_ex = {2'b00, w_eb} + 10'd33;
        end else begin
            w_n  = w_s[26:0] << w_lz;
            w_ex = {2'b00, w_eb} + 10'd32 - {5'd0, w_lz};
        end
        w_r   = {1'b0, w_n[26:3]} + {24'd0, w_n[2] & ((|w_n[1:0]) | w_n[3])};
        w_ex2 = w_ex + {9'd0, w_r[24]};
        w_ef  = w_ex2 - 10'd32;
        if (w_eb == 8'hFF)          w_res = w_big;
        else if (w_s == 28'd0)      w_res = {w_big[31] & w_sml[31], 31'd0};
        else if (w_ex2 <= 10'd32)   w_res = {w_big[31], 31'd0};
        else if (w_ex2 >= 10'd287)  w_res = {w_big[31], 8'hFF, 23'd0};
        else                        w_res = {w_big[31], w_ef[7:0],
                                             w_r[24] ? w_r[23:1] : w_r[22:0]};
    end

    fp_delay #(.STAGES(LAT - 1)) u_dly (.clk(clk), .rstn(rstn), .i_d(w_res), .o_q(o_y));
endmodule

// Single-precision multiplier, same latency structure as single_add.
module single_mult #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    logic [47:0] w_p;
    logic [23:0] w_m;
    logic [24:0] w_r;
    logic [9:0]  w_ex, w_ef;
    logic [31:0] w_res;
    logic        w_g, w_st, w_nrm, w_sgn;

    // 24x24 mantissa product, normalise one bit, round to nearest even
    always_comb begin
        w_sgn = i_a[31] ^ i_b[31];
        w_p   = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});
        w_nrm = w_p[47];
        if (w_nrm) begin
            w_m  = w_p[47:24];
            w_g  = w_p[23];
            w_st = |w_p[22:0];
        end else begin
            w_m  = w_p[46:23];
            w_g  = w_p[22];
            w_st = |w_p[21:0];
        end
        w_r  = {1'b0, w_m} + {24'd0, w_g & (w_st | w_m[0])};
        w_ex = {2'b00, i_a[30:23]} + {2'b00, i_b[30:23]} + {9'd0, w_nrm} + {9'd0, w_r[24]};
        w_ef = w_ex - 10'd127;
        if (i_a[30:23] == 8'hFF || i_b[30:23] == 8'hFF)   w_res = {w_sgn, 8'hFF, 23'd0};
        else if (i_a[30:23] == 8'd0 || i_b[30:23] == 8'd0) w_res = {w_sgn, 31'd0};
        else if (w_ex <= 10'd127)                          w_res = {w_sgn, 31'd0};
        else if (w_ex >= 10'd382)                          w_res = {w_sgn, 8'hFF, 23'd0};
        else w_res = {w_sgn, w_ef[7:0], w_r[24] ? w_r[23:1] : w_r[22:0]};
    end

    fp_delay #(.STAGES(LAT - 1)) u_dly (.clk(clk), .rstn(rstn), .i_d(w_res), .o_q(o_y));
endmodule

module single_backprop_layer2 #(
    parameter int LAYER2_NEURONS = 10,
    parameter int OUTPUT_NODES   = 10,
    parameter int MULT_LAT       = 1,
    parameter int ADD_LAT        = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] y   [OUTPUT_NODES],
    input  logic [31:0] t   [OUTPUT_NODES],
    input  logic [31:0] l   [LAYER2_NEURONS],
    input  logic [31:0] W2  [LAYER2_NEURONS][OUTPUT_NODES],
    output logic        done,
    output logic [31:0] dW2 [LAYER2_NEURONS][OUTPUT_NODES],
    output logic [31:0] db2 [OUTPUT_NODES],
    output logic [31:0] dl  [LAYER2_NEURONS]
);
    localparam int IW = (LAYER2_NEURONS > 1) ? $clog2(LAYER2_NEURONS) : 1;
    localparam int JW = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1;
    localparam logic [IW-1:0] c_I_LAST = IW'(LAYER2_NEURONS - 1);
    localparam logic [JW-1:0] c_J_LAST = JW'(OUTPUT_NODES - 1);
    localparam logic [7:0]    c_M_LAST = 8'(MULT_LAT - 1);
    localparam logic [7:0]    c_A_LAST = 8'(ADD_LAT - 1);

    // CLEAR is the cycle following an accepted start; PROP is split into its
    // multiply and add halves so the adder sees a stable registered product.
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_DELTA, S_GRAD, S_PMUL, S_PADD, S_DONE
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_i;
    logic [JW-1:0] r_j;
    logic [7:0]    r_wait;
    logic [31:0]   r_prod;
    logic          r_armed;
    logic [31:0]   w_add_a, w_add_b, w_add_y, w_mul_a, w_mul_b, w_mul_y;

    // operand steering: adder does deltas or dl accumulation, multiplier
    // does gradient or propagation products
    always_comb begin
        w_add_a = dl[r_i];
        w_add_b = r_prod;
        if (r_state == S_DELTA) begin
            w_add_a = y[r_j];
            w_add_b = {~t[r_j][31], t[r_j][30:0]};
        end
        w_mul_a = (r_state == S_GRAD) ? l[r_i] : W2[r_i][r_j];
        w_mul_b = db2[r_j];
    end

    single_add  #(.LAT(ADD_LAT))  u_add (.clk(clk), .rstn(rstn), .i_a(w_add_a), .i_b(w_add_b), .o_y(w_add_y));
    single_mult #(.LAT(MULT_LAT)) u_mul (.clk(clk), .rstn(rstn), .i_a(w_mul_a), .i_b(w_mul_b), .o_y(w_mul_y));

    // sequencer: walks delta, then (grad, prop) for every (i, j), writing
    // each result on the edge it becomes valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_wait  <= '0;
            r_prod  <= '0;
            r_armed <= 1'b0;
            done    <= 1'b0;
            for (int a = 0; a < OUTPUT_NODES; a++) db2[a] <= '0;
            for (int a = 0; a < LAYER2_NEURONS; a++) begin
                dl[a] <= '0;
                for (int b = 0; b < OUTPUT_NODES; b++) dW2[a][b] <= '0;
            end
        end else begin
            // a start on the first edge after reset release is not accepted
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && r_armed) begin
                        done    <= 1'b0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_wait  <= '0;
                        r_state <= S_CLEAR;
                        for (int a = 0; a < LAYER2_NEURONS; a++) dl[a] <= '0;
                    end
                end
                S_CLEAR: r_state <= S_DELTA;
                S_DELTA: begin
                    if (r_wait == c_A_LAST) begin
                        r_wait   <= '0;
                        db2[r_j] <= w_add_y;
                        if (r_j == c_J_LAST) begin
                            r_j     <= '0;
                            r_state <= S_GRAD;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_GRAD: begin
                    if (r_wait == c_M_LAST) begin
                        r_wait        <= '0;
                        dW2[r_i][r_j] <= w_mul_y;
                        r_state       <= S_PMUL;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_PMUL: begin
                    if (r_wait == c_M_LAST) begin
                        r_wait  <= '0;
                        r_prod  <= w_mul_y;
                        r_state <= S_PADD;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_PADD: begin
                    if (r_wait == c_A_LAST) begin
                        r_wait  <= '0;
                        dl[r_i] <= w_add_y;
                        r_state <= S_GRAD;
                        if (r_j != c_J_LAST) begin
                            r_j <= r_j + 1'b1;
                        end else if (r_i != c_I_LAST) begin
                            r_i <= r_i + 1'b1;
                            r_j <= '0;
                        end else begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_single_backprop_layer2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_single_backprop_layer2
//  Purpose  : Directed checks of single_backprop_layer2 at L=O=2, with one
//             instance at unit latencies and one at MULT_LAT=3, ADD_LAT=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_single_backprop_layer2;
    localparam int L = 2;
    localparam int O = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] y [O];
    logic [31:0] t [O];
    logic [31:0] l [L];
    logic [31:0] W2 [L][O];
    logic        done_a, done_b;
    logic [31:0] dW2_a [L][O], dW2_b [L][O];
    logic [31:0] db2_a [O], db2_b [O];
    logic [31:0] dl_a [L], dl_b [L];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    single_backprop_layer2 #(.LAYER2_NEURONS(L), .OUTPUT_NODES(O), .MULT_LAT(1), .ADD_LAT(1)) u_dut_a (
        .clk(clk), .rstn(rstn), .start(start), .y(y), .t(t), .l(l), .W2(W2),
        .done(done_a), .dW2(dW2_a), .db2(db2_a), .dl(dl_a));

    single_backprop_layer2 #(.LAYER2_NEURONS(L), .OUTPUT_NODES(O), .MULT_LAT(3), .ADD_LAT(2)) u_dut_b (
        .clk(clk), .rstn(rstn), .start(start), .y(y), .t(t), .l(l), .W2(W2),
        .done(done_b), .dW2(dW2_b), .db2(db2_b), .dl(dl_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // compare every output word of both instances against one expected set
    task automatic chk_all(input string tag,
                           input logic [31:0] e_db0, input logic [31:0] e_db1,
                           input logic [31:0] e_w00, input logic [31:0] e_w01,
                           input logic [31:0] e_w10, input logic [31:0] e_w11,
                           input logic [31:0] e_dl0, input logic [31:0] e_dl1);
        chk({tag, "_a_db2_0"}, db2_a[0], e_db0);
        chk({tag, "_a_db2_1"}, db2_a[1], e_db1);
        chk({tag, "_a_dw2_00"}, dW2_a[0][0], e_w00);
        chk({tag, "_a_dw2_01"}, dW2_a[0][1], e_w01);
        chk({tag, "_a_dw2_10"}, dW2_a[1][0], e_w10);
        chk({tag, "_a_dw2_11"}, dW2_a[1][1], e_w11);
        chk({tag, "_a_dl_0"}, dl_a[0], e_dl0);
        chk({tag, "_a_dl_1"}, dl_a[1], e_dl1);
        chk({tag, "_b_db2_0"}, db2_b[0], e_db0);
        chk({tag, "_b_db2_1"}, db2_b[1], e_db1);
        chk({tag, "_b_dw2_00"}, dW2_b[0][0], e_w00);
        chk({tag, "_b_dw2_01"}, dW2_b[0][1], e_w01);
        chk({tag, "_b_dw2_10"}, dW2_b[1][0], e_w10);
        chk({tag, "_b_dw2_11"}, dW2_b[1][1], e_w11);
        chk({tag, "_b_dl_0"}, dl_b[0], e_dl0);
        chk({tag, "_b_dl_1"}, dl_b[1], e_dl1);
    endtask

    // pulse start (sampled at edge S), then watch 60 edges recording the first
    // edge offset at which each done is high; busy_at>0 re-pulses start so it
    // is sampled at S+busy_at
    task automatic run(input int busy_at, output int lat_a, output int lat_b, output logic done_a1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat_a = 0;
        lat_b = 0;
        done_a1 = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1) done_a1 = done_a;
            if (lat_a == 0 && done_a) lat_a = c;
            if (lat_b == 0 && done_b) lat_b = c;
            start = (c == busy_at - 1);
        end
        start = 1'b0;
    endtask

    int   la, lb;
    logic d1;
    logic [31:0] acc;
    logic        any_done;

    initial begin
        y[0] = 32'h3F80_0000; y[1] = 32'h3F00_0000;
        t[0] = 32'h0000_0000; t[1] = 32'h3F80_0000;
        l[0] = 32'h4000_0000; l[1] = 32'h4080_0000;
        W2[0][0] = 32'h3F80_0000; W2[0][1] = 32'h3F80_0000;
        W2[1][0] = 32'h4000_0000; W2[1][1] = 32'h0000_0000;

        // reset, then 20 idle cycles with all outputs zero
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        acc = '0;
        any_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            any_done = any_done | done_a | done_b;
            acc = acc | db2_a[0] | db2_a[1] | dl_a[0] | dl_a[1]
                      | dW2_a[0][0] | dW2_a[0][1] | dW2_a[1][0] | dW2_a[1][1]
                      | db2_b[0] | db2_b[1] | dl_b[0] | dl_b[1]
                      | dW2_b[0][0] | dW2_b[0][1] | dW2_b[1][0] | dW2_b[1][1];
        end
        chk("rst_done", {31'd0, any_done}, 32'd0);
        chk("rst_outs", acc, 32'd0);

        // basic run, both latency configurations
        run(0, la, lb, d1);
        chk("basic_lat_a", 32'(la), 32'd15);
        chk("basic_lat_b", 32'(lb), 32'd37);
        chk_all("basic", 32'h3F80_0000, 32'hBF00_0000,
                32'h4000_0000, 32'hBF80_0000, 32'h4080_0000, 32'hC000_0000,
                32'h3F00_0000, 32'h4000_0000);

        // start while busy is ignored
        run(5, la, lb, d1);
        chk("busy_lat_a", 32'(la), 32'd15);
        chk("busy_lat_b", 32'(lb), 32'd37);
        chk_all("busy", 32'h3F80_0000, 32'hBF00_0000,
                32'h4000_0000, 32'hBF80_0000, 32'h4080_0000, 32'hC000_0000,
                32'h3F00_0000, 32'h4000_0000);

        // re-run from DONE with new y: delta = {2, 0}
        y[0] = 32'h4000_0000; y[1] = 32'h3F80_0000;
        run(0, la, lb, d1);
        chk("rerun_done_fall", {31'd0, d1}, 32'd0);
        chk("rerun_lat_a", 32'(la), 32'd15);
        chk("rerun_lat_b", 32'(lb), 32'd37);
        chk_all("rerun", 32'h4000_0000, 32'h0000_0000,
                32'h4080_0000, 32'h0000_0000, 32'h4100_0000, 32'h0000_0000,
                32'h4000_0000, 32'h4080_0000);

        // abort at S+7 with original vectors, then a clean rerun
        y[0] = 32'h3F80_0000; y[1] = 32'h3F00_0000;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("abort_done_a", {31'd0, done_a}, 32'd0);
        chk("abort_db2_a0", db2_a[0], 32'd0);
        chk("abort_dw2_a10", dW2_a[1][0], 32'd0);
        chk("abort_dw2_b10", dW2_b[1][0], 32'd0);
        chk("abort_dl_b0", dl_b[0], 32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        run(0, la, lb, d1);
        chk("abort_lat_a", 32'(la), 32'd15);
        chk("abort_lat_b", 32'(lb), 32'd37);
        chk_all("abort", 32'h3F80_0000, 32'hBF00_0000,
                32'h4000_0000, 32'hBF80_0000, 32'h4080_0000, 32'hC000_0000,
                32'h3F00_0000, 32'h4000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
